bmf_decomp_pipe: RTL and testbench

- Pipelined Boolean-matrix-factorization decompressor, the H-stage partner of the BMF compressor (W-stage) in approximated partitions.
- Consumes K-bit latent codes and reconstructs M output bits as a Boolean matrix-vector product: out[j] = OR over i of (code[i] & H[i][j]).
- H is held in registers and is runtime-programmable, so one block serves any k-factorized partition of matching size.
- Valid/ready streaming with 2-stage elastic pipeline, plus a beat counter for error-rate measurement benches.

---
 rtl/bmf_pkg.sv | 45 ++++
 rtl/bmf_decomp_pipe_if.sv | 24 ++
 rtl/bmf_bool_product.sv | 25 ++
 rtl/bmf_decomp_pipe.sv | 94 +++++++++
 tb/tb_bmf_decomp_pipe.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/bmf_pkg.sv
// Shared types and helpers for the BMF H-stage decompressor.
// Build option BMF_XOR_SEMIRING_EN switches the reduction from OR to GF(2) XOR.
package bmf_pkg;

    localparam int K_DEF = 3;
    localparam int M_DEF = 4;
    localparam int K_MAX = 8;
    localparam int M_MAX = 32;

    typedef logic [M_MAX-1:0]             h_row_t;
    typedef logic [K_MAX-1:0][M_MAX-1:0]  h_mat_t;
    typedef logic [K_MAX-1:0]             code_t;

    // Row i drives output bit i+1, so out[0] stays 0 and out[i+1] = k_i.
    function automatic h_mat_t default_h(input int k, input int m);
        h_mat_t h;
        h = '0;
        for (int i = 0; i < K_MAX; i++) begin
            if ((i < k) && ((i + 1) < m)) begin
                h[i][i+1] = 1'b1;
            end else begin
                h[i] = '0;
            end
        end
        return h;
    endfunction

    function automatic h_row_t bool_mat_vec(input code_t code, input h_mat_t h);
        h_row_t acc;
        acc = '0;
        for (int i = 0; i < K_MAX; i++) begin
            if (code[i]) begin
`ifdef BMF_XOR_SEMIRING_EN
                acc = acc ^ h[i];
`else
                acc = acc | h[i];
`endif
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/bmf_decomp_pipe_if.sv
// Streaming handshake bundle: latent codes in, reconstructed words out.
interface bmf_decomp_pipe_if
    import bmf_pkg::*;
#(
    parameter int K = K_DEF,
    parameter int M = M_DEF
);
    logic         in_valid;
    logic         in_ready;
    logic [K-1:0] in_code;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] out_data;

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/bmf_bool_product.sv
// Combinational Boolean matrix-vector product of a latent code with H.
module bmf_bool_product
    import bmf_pkg::*;
#(
    parameter int K = K_DEF,
    parameter int M = M_DEF
) (
    input  logic [K-1:0]        code,
    input  logic [K-1:0][M-1:0] h,
    output logic [M-1:0]        prod
);
    code_t  code_wide_s;
    h_mat_t h_wide_s;

    // Widen to the package's maximum shape so one reduction function serves every size.
    always_comb begin
        code_wide_s        = '0;
        h_wide_s           = '0;
        code_wide_s[K-1:0] = code;
        for (int i = 0; i < K; i++) begin
            h_wide_s[i][M-1:0] = h[i];
        end
        prod = M'(bool_mat_vec(code_wide_s, h_wide_s));
    end
endmodule

// File: rtl/bmf_decomp_pipe.sv
// Two-stage elastic BMF decompressor with programmable H and a beat counter.
// Build option BMF_XOR_SEMIRING_EN selects the XOR (GF(2)) product.
module bmf_decomp_pipe
    import bmf_pkg::*;
#(
    parameter int K     = K_DEF,
    parameter int M     = M_DEF,
    parameter int CNT_W = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    bmf_decomp_pipe_if.slave                     bus,
    input  logic                                 cfg_we,
    input  logic [((K > 1) ? $clog2(K) : 1)-1:0] cfg_row,
    input  logic [M-1:0]                         cfg_data,
    output logic [CNT_W-1:0]                     beat_cnt
);
    localparam h_mat_t H_DEF = default_h(K, M);

    logic [K-1:0][M-1:0] h_r;
    logic [K-1:0]        s1_code_r;
    logic                s1_valid_r;
    logic                s2_valid_r;
    logic [M-1:0]        s2_data_r;
    logic [CNT_W-1:0]    beat_cnt_r;
    logic [M-1:0]        prod_s;
    logic                s2_adv_s;
    logic                s1_adv_s;
    logic                in_ready_s;

    bmf_bool_product #(.K(K), .M(M)) u_product (
        .code (s1_code_r),
        .h    (h_r),
        .prod (prod_s)
    );

    // Advance conditions: in_ready follows out_ready but never in_valid.
    always_comb begin
        s2_adv_s   = !s2_valid_r || bus.out_ready;
        s1_adv_s   = s1_valid_r && s2_adv_s;
        in_ready_s = !s1_valid_r || s2_adv_s;
    end

    // Stage 1: capture the incoming latent code.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_code_r  <= '0;
        end else if (in_ready_s) begin
            s1_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                s1_code_r <= bus.in_code;
            end
        end
    end

    // Stage 2: register the product; held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_data_r  <= '0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_adv_s) begin
                s2_data_r <= prod_s;
            end
        end
    end

    // H rows: the product sampled at a write edge still sees the old row.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                h_r[i] <= M'(H_DEF[i]);
            end
        end else if (cfg_we && (int'(cfg_row) < K)) begin
            h_r[cfg_row] <= cfg_data;
        end
    end

    // Completed output transfers, wrapping at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_r <= '0;
        end else if (s2_valid_r && bus.out_ready) begin
            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = s2_valid_r;
    assign bus.out_data  = s2_data_r;
    assign beat_cnt      = beat_cnt_r;
endmodule

// File: tb/tb_bmf_decomp_pipe.sv
// Directed self-checking bench for bmf_decomp_pipe (main instance plus a CNT_W=4 wrap instance).
module tb_bmf_decomp_pipe;

`ifdef BMF_XOR_SEMIRING_EN
    localparam logic [3:0] EXP_CFG = 4'b0101;
`else
    localparam logic [3:0] EXP_CFG = 4'b0111;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_row;
    logic [3:0]  cfg_data;
    logic [15:0] beat_cnt;
    logic [3:0]  beat4;
    int          pass_cnt  = 0;
    int          total_cnt = 0;

    bmf_decomp_pipe_if #(.K(3), .M(4)) bus ();
    bmf_decomp_pipe_if #(.K(3), .M(4)) bus4 ();

    bmf_decomp_pipe #(.K(3), .M(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_data(cfg_data), .beat_cnt(beat_cnt)
    );

    bmf_decomp_pipe #(.K(3), .M(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4),
        .cfg_we(1'b0), .cfg_row(2'b00), .cfg_data(4'b0000), .beat_cnt(beat4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cfg_we = 1'b0; cfg_row = 2'd0; cfg_data = 4'd0;
        bus.in_valid = 1'b0; bus.in_code = 3'd0; bus.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_code = 3'd0; bus4.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.out_ready = 1'b0;
        tick();
        tick();
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); else pass_cnt++;
        total_cnt++; if (bus.out_data !== 4'b0000) $display("FAIL rst_out_data: got %b expected 0000", bus.out_data); else pass_cnt++;
        total_cnt++; if (beat_cnt !== 16'd0) $display("FAIL rst_beat_cnt: got %0d expected 0", beat_cnt); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] codes [3];
        logic [3:0] exp_w [3];
        codes = '{3'b101, 3'b010, 3'b111};
        exp_w = '{4'b1010, 4'b0100, 4'b1110};
        do_reset();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = (c < 3);
            bus.in_code  = codes[c % 3];
            #1;
            total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL bb_in_ready[%0d]: got %b expected 1", c, bus.in_ready); else pass_cnt++;
            tick();
            if (c == 0) begin
                total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL bb_latency: out_valid got %b expected 0", bus.out_valid); else pass_cnt++;
            end else if (c <= 3) begin
                total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_w[c-1])
                    $display("FAIL bb_word[%0d]: got valid=%b data=%b expected valid=1 data=%b", c - 1, bus.out_valid, bus.out_data, exp_w[c-1]); else pass_cnt++;
            end else begin
                total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL bb_drain: out_valid got %b expected 0", bus.out_valid); else pass_cnt++;
            end
        end
        total_cnt++; if (beat_cnt !== 16'd3) $display("FAIL bb_beat_cnt: got %0d expected 3", beat_cnt); else pass_cnt++;
    endtask

    task automatic test_cfg_write();
        do_reset();
        bus.out_ready = 1'b1;
        cfg_we = 1'b1; cfg_row = 2'd0; cfg_data = 4'b0011;
        tick();
        cfg_row = 2'd1; cfg_data = 4'b0110;
        tick();
        cfg_we = 1'b0;
        bus.in_valid = 1'b1; bus.in_code = 3'b011;
        tick();
        bus.in_valid = 1'b0;
        tick();
        total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_data !== EXP_CFG)
            $display("FAIL cfg_product: got valid=%b data=%b expected valid=1 data=%b", bus.out_valid, bus.out_data, EXP_CFG); else pass_cnt++;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_code = 3'b001;
        #1;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL bp_empty_ready: got %b expected 1", bus.in_ready); else pass_cnt++;
        tick();
        bus.in_code = 3'b010;
        tick();
        bus.in_code = 3'b100;
        #1;
        total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL bp_full_ready: got %b expected 0", bus.in_ready); else pass_cnt++;
        total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'b0010)
            $display("FAIL bp_first: got valid=%b data=%b expected valid=1 data=0010", bus.out_valid, bus.out_data); else pass_cnt++;
        tick();
        total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'b0010)
            $display("FAIL bp_hold: got valid=%b data=%b expected valid=1 data=0010", bus.out_valid, bus.out_data); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL bp_still_full: got %b expected 0", bus.in_ready); else pass_cnt++;
        bus.out_ready = 1'b1;
        #1;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready); else pass_cnt++;
        tick();
        bus.in_valid = 1'b0;
        total_cnt++; if (bus.out_data !== 4'b0100) $display("FAIL bp_second: got %b expected 0100", bus.out_data); else pass_cnt++;
        tick();
        total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'b1000)
            $display("FAIL bp_third: got valid=%b data=%b expected valid=1 data=1000", bus.out_valid, bus.out_data); else pass_cnt++;
        tick();
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL bp_empty: out_valid got %b expected 0", bus.out_valid); else pass_cnt++;
        total_cnt++; if (beat_cnt !== 16'd3) $display("FAIL bp_beat_cnt: got %0d expected 3", beat_cnt); else pass_cnt++;
    endtask

    task automatic test_cfg_same_edge();
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_code = 3'b001;
        tick();
        cfg_we = 1'b1; cfg_row = 2'd0; cfg_data = 4'b0001;
        tick();
        cfg_we = 1'b0; bus.in_valid = 1'b0;
        total_cnt++; if (bus.out_data !== 4'b0010) $display("FAIL same_edge_old_row: got %b expected 0010", bus.out_data); else pass_cnt++;
        tick();
        total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'b0001)
            $display("FAIL same_edge_new_row: got valid=%b data=%b expected valid=1 data=0001", bus.out_valid, bus.out_data); else pass_cnt++;
        tick();
        cfg_we = 1'b1; cfg_row = 2'd3; cfg_data = 4'b1111;
        tick();
        cfg_we = 1'b0;
        bus.in_valid = 1'b1; bus.in_code = 3'b101;
        tick();
        bus.in_valid = 1'b0;
        tick();
        total_cnt++; if (bus.out_data !== 4'b1001) $display("FAIL cfg_row_oob: got %b expected 1001", bus.out_data); else pass_cnt++;
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.out_ready = 1'b1;
        cfg_we = 1'b1; cfg_row = 2'd0; cfg_data = 4'b1111;
        tick();
        cfg_we = 1'b0;
        bus.in_valid = 1'b1; bus.in_code = 3'b010;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        total_cnt++; if (beat_cnt !== 16'd1) $display("FAIL mr_beat_before: got %0d expected 1", beat_cnt); else pass_cnt++;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_code = 3'b001;
        tick();
        bus.in_code = 3'b010;
        tick();
        bus.in_valid = 1'b0;
        total_cnt++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
            $display("FAIL mr_full: got valid=%b ready=%b expected valid=1 ready=0", bus.out_valid, bus.in_ready); else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL mr_out_valid: got %b expected 0", bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL mr_in_ready: got %b expected 1", bus.in_ready); else pass_cnt++;
        total_cnt++; if (beat_cnt !== 16'd0) $display("FAIL mr_beat_cnt: got %0d expected 0", beat_cnt); else pass_cnt++;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_code = 3'b001;
        tick();
        bus.in_valid = 1'b0;
        tick();
        total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'b0010)
            $display("FAIL mr_h_default: got valid=%b data=%b expected valid=1 data=0010", bus.out_valid, bus.out_data); else pass_cnt++;
        tick();
    endtask

    task automatic test_wrap();
        logic [2:0] k;
        do_reset();
        bus4.out_ready = 1'b1;
        for (int c = 0; c < 19; c++) begin
            bus4.in_valid = (c < 17);
            bus4.in_code  = 3'(c);
            #1;
            if (c < 17) begin
                total_cnt++; if (bus4.in_ready !== 1'b1) $display("FAIL wrap_in_ready[%0d]: got %b expected 1", c, bus4.in_ready); else pass_cnt++;
            end
            tick();
            if (c >= 1 && c <= 17) begin
                k = 3'(c - 1);
                total_cnt++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== {k, 1'b0})
                    $display("FAIL wrap_word[%0d]: got valid=%b data=%b expected valid=1 data=%b", c - 1, bus4.out_valid, bus4.out_data, {k, 1'b0}); else pass_cnt++;
            end
            if (c == 17) begin
                total_cnt++; if (beat4 !== 4'd0) $display("FAIL wrap_16: got %0d expected 0", beat4); else pass_cnt++;
            end
        end
        total_cnt++; if (bus4.out_valid !== 1'b0) $display("FAIL wrap_drain: out_valid got %b expected 0", bus4.out_valid); else pass_cnt++;
        total_cnt++; if (beat4 !== 4'd1) $display("FAIL wrap_17: got %0d expected 1", beat4); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_row = 2'd0; cfg_data = 4'd0;
        bus.in_valid = 1'b0; bus.in_code = 3'd0; bus.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_code = 3'd0; bus4.out_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_cfg_write();
        test_backpressure();
        test_cfg_same_edge();
        test_mid_reset();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
